// File: rtl/ysyx_23060184_lsu.sv
// ----------------------------------------------------------------------------
// ysyx_23060184_lsu
// Memory-stage load/store unit. It is the downstream end of the execute-stage
// Evalid/Mready handshake, issues at most one req/gnt/rvalid access to data
// memory per transaction, and hands the result to writeback via Mvalid/Wready.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   Evalid / Mready           execute handshake (Mready=1 only in IDLE)
//   ALUResult, StoreData      address or pass-through value, store source
//   MemRead, MemWrite         load / store (both set -> load)
//   MemSize, MemSign          00 byte, 01 half, 1x word; sign-extend loads
//   mem_req/we/addr/wdata/wmask  data-memory request side
//   mem_gnt, mem_rvalid, mem_rdata  data-memory grant and response
//   Mvalid / Wready           writeback handshake
//   MemResult, ALUOut, Merr   load value or ALU result, captured ALU result,
//                             misaligned-access flag
// Only DATA_WIDTH = 32 (four byte lanes) is supported.
// ----------------------------------------------------------------------------
module ysyx_23060184_lsu #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  Evalid,
    output logic                  Mready,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] StoreData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [1:0]            MemSize,
    input  logic                  MemSign,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wmask,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  Mvalid,
    input  logic                  Wready,
    output logic [DATA_WIDTH-1:0] MemResult,
    output logic [DATA_WIDTH-1:0] ALUOut,
    output logic                  Merr
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            r_off;
    logic [1:0]            r_size;
    logic                  r_sign;
    logic                  r_is_load;
    logic                  r_we;
    logic [3:0]            r_wmask;
    logic                  r_merr;
    logic [DATA_WIDTH-1:0] r_alu;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_result;

    // Decode of the incoming execute-stage operation.
    logic                  w_is_mem;
    logic                  w_is_store;
    logic [1:0]            w_size;
    logic                  w_misaligned;
    logic [3:0]            w_mask;
    logic [DATA_WIDTH-1:0] w_shifted;
    logic [DATA_WIDTH-1:0] w_load_result;
    logic [DATA_WIDTH-1:0] w_resp_result;

    assign w_is_mem   = MemRead | MemWrite;
    // A simultaneous read and write is a load, so only a pure write stores.
    assign w_is_store = MemWrite & ~MemRead;
    assign w_size     = (MemSize == 2'b11) ? 2'b10 : MemSize;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_misaligned = 1'b0;
        w_mask       = 4'b1111;
        case (w_size)
            2'b00: w_mask = 4'b0001 << ALUResult[1:0];
            2'b01: begin
                w_mask       = 4'b0011 << ALUResult[1:0];
                w_misaligned = ALUResult[0];
            end
            default: w_misaligned = (ALUResult[1:0] != 2'b00);
        endcase
        w_misaligned = w_misaligned & w_is_mem;
    end

    // Response lane alignment and extension, using the captured offset/size.
    assign w_shifted = mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_load_result = w_shifted;
        case (r_size)
            2'b00: w_load_result = {{24{r_sign & w_shifted[7]}},  w_shifted[7:0]};
            2'b01: w_load_result = {{16{r_sign & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_result = w_shifted;
        endcase
    end

    // A store's response is only an acknowledgement; it reports the address.
    assign w_resp_result = r_is_load ? w_load_result : r_alu;

    // NOTE: reset is synchronous here, so it is sampled inside the clocked
    // branch rather than listed in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of the others.
            r_state   <= S_IDLE;
            r_off     <= 2'b00;
            r_size    <= 2'b00;
            r_sign    <= 1'b0;
            r_is_load <= 1'b0;
            r_we      <= 1'b0;
            r_wmask   <= 4'b0000;
            r_merr    <= 1'b0;
            r_alu     <= '0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_result  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Evalid) begin
                        r_alu     <= ALUResult;
                        r_addr    <= {ALUResult[DATA_WIDTH-1:2], 2'b00};
                        r_wdata   <= StoreData << {ALUResult[1:0], 3'b000};
                        r_wmask   <= w_is_store ? w_mask : 4'b0000;
                        r_we      <= w_is_store;
                        r_off     <= ALUResult[1:0];
                        r_size    <= w_size;
                        r_sign    <= MemSign;
                        r_is_load <= MemRead;
                        r_merr    <= w_misaligned;
                        if (w_misaligned) begin
                            r_result <= '0;
                            r_state  <= S_DONE;
                        end else if (!w_is_mem) begin
                            r_result <= ALUResult;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        if (mem_rvalid) begin
                            r_result <= w_resp_result;
                            r_state  <= S_DONE;
                        end else begin
                            r_state  <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        r_result <= w_resp_result;
                        r_state  <= S_DONE;
                    end
                end
                default: begin
                    if (Wready) r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Mready    = (r_state == S_IDLE);
    assign Mvalid    = (r_state == S_DONE);
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = mem_req & r_we;
    assign mem_wmask = mem_req ? r_wmask : 4'b0000;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign MemResult = r_result;
    assign ALUOut    = r_alu;
    assign Merr      = r_merr;

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// ----------------------------------------------------------------------------
// tb_ysyx_23060184_lsu
// Self-checking bench for the load/store unit. Directed scenarios followed by
// randomized operations; expected values come from a byte-lane reference
// model built from plain arithmetic.
// ----------------------------------------------------------------------------
module tb_ysyx_23060184_lsu;

    logic        clk;
    logic        rstn;
    logic        Evalid;
    logic        Mready;
    logic [31:0] ALUResult;
    logic [31:0] StoreData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemSign;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        Mvalid;
    logic        Wready;
    logic [31:0] MemResult;
    logic [31:0] ALUOut;
    logic        Merr;

    int n_checks = 0;
    int n_fails  = 0;

    ysyx_23060184_lsu #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rstn(rstn), .Evalid(Evalid), .Mready(Mready),
        .ALUResult(ALUResult), .StoreData(StoreData), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemSize(MemSize), .MemSign(MemSign),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .Mvalid(Mvalid),
        .Wready(Wready), .MemResult(MemResult), .ALUOut(ALUOut), .Merr(Merr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-lane view) ----------------
    function automatic int nbytes(input logic [1:0] sz);
        case (sz)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] ref_mask(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] m;
        int off;
        m   = 4'b0000;
        off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= off && i < off + nbytes(sz)) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] sd, input logic [31:0] a);
        logic [31:0] w;
        int off;
        w   = 32'h0;
        off = int'(a % 4);
        for (int i = 0; i < 4; i++)
            if (i >= off) w[8*i +: 8] = sd[8*(i-off) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg,
                                             input logic [31:0] a, input logic [31:0] rd);
        longint v;
        longint span;
        int off;
        int nb;
        v    = 0;
        off  = int'(a % 4);
        nb   = nbytes(sz);
        span = longint'(1) << (8 * nb);
        for (int k = 0; k < nb; k++)
            v += longint'(rd[8*(off+k) +: 8]) << (8 * k);
        if (sg && nb < 4 && v >= span / 2) v = v - span;
        return v[31:0];
    endfunction

    // One complete transaction from IDLE back to IDLE, checking every phase.
    task automatic run_op(input logic rd, input logic wr, input logic [1:0] sz,
                          input logic sg, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [31:0] rdata, input int gnt_dly, input bit same,
                          input int rv_dly, input int wr_dly);
        logic        is_mem;
        logic        is_store;
        logic        mis;
        logic [31:0] exp_res;
        logic [3:0]  exp_mask;
        is_mem   = rd | wr;
        is_store = wr & ~rd;
        mis      = is_mem && ((addr % nbytes(sz)) != 0);
        exp_mask = is_store ? ref_mask(sz, addr) : 4'b0000;

        chk("mready_idle", {31'b0, Mready}, 32'd1);
        Evalid = 1'b1; ALUResult = addr; StoreData = sdata;
        MemRead = rd; MemWrite = wr; MemSize = sz; MemSign = sg;
        step();
        // Scramble inputs so any late capture shows up.
        Evalid = 1'b0; ALUResult = $urandom; StoreData = $urandom;
        MemRead = 1'($urandom); MemWrite = 1'($urandom);
        MemSize = 2'($urandom); MemSign = 1'($urandom);

        if (!is_mem || mis) begin
            exp_res = mis ? 32'h0 : addr;
        end else begin
            chk("req_up",   {31'b0, mem_req}, 32'd1);
            chk("req_mval", {31'b0, Mvalid},  32'd0);
            chk("req_mrdy", {31'b0, Mready},  32'd0);
            chk("req_addr", mem_addr, addr & 32'hFFFF_FFFC);
            chk("req_we",   {31'b0, mem_we}, {31'b0, is_store});
            chk("req_mask", {28'b0, mem_wmask}, {28'b0, exp_mask});
            if (is_store) chk("req_wdata", mem_wdata, ref_wdata(sdata, addr));
            for (int i = 0; i < gnt_dly; i++) begin
                Evalid = 1'b1; ALUResult = $urandom;
                step();
                chk("req_held", {31'b0, mem_req}, 32'd1);
                chk("req_hold_addr", mem_addr, addr & 32'hFFFF_FFFC);
                chk("req_hold_mask", {28'b0, mem_wmask}, {28'b0, exp_mask});
            end
            Evalid = 1'b0;
            mem_gnt = 1'b1; mem_rvalid = same; mem_rdata = same ? rdata : $urandom;
            step();
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (!same) begin
                chk("wait_req",  {31'b0, mem_req}, 32'd0);
                chk("wait_mask", {28'b0, mem_wmask}, 32'd0);
                chk("wait_mval", {31'b0, Mvalid}, 32'd0);
                for (int i = 0; i < rv_dly; i++) begin
                    step();
                    chk("wait_mval_hold", {31'b0, Mvalid}, 32'd0);
                end
                mem_rvalid = 1'b1; mem_rdata = rdata;
                step();
                mem_rvalid = 1'b0; mem_rdata = $urandom;
            end
            exp_res = rd ? ref_load(sz, sg, addr, rdata) : addr;
        end

        chk("done_mval",   {31'b0, Mvalid}, 32'd1);
        chk("done_result", MemResult, exp_res);
        chk("done_merr",   {31'b0, Merr}, {31'b0, mis});
        chk("done_aluout", ALUOut, addr);
        chk("done_noreq",  {31'b0, mem_req}, 32'd0);
        for (int i = 0; i < wr_dly; i++) begin
            Evalid = 1'b1; ALUResult = $urandom;
            step();
            chk("hold_mval",   {31'b0, Mvalid}, 32'd1);
            chk("hold_result", MemResult, exp_res);
            chk("hold_aluout", ALUOut, addr);
            chk("hold_mrdy",   {31'b0, Mready}, 32'd0);
        end
        Evalid = 1'b0; Wready = 1'b1;
        step();
        Wready = 1'b0;
        chk("handoff_mval", {31'b0, Mvalid}, 32'd0);
        chk("handoff_mrdy", {31'b0, Mready}, 32'd1);
    endtask

    initial begin
        logic [1:0]  sz;
        logic        rd;
        logic        wr;
        logic [31:0] a;

        rstn = 1'b0; Evalid = 1'b0; ALUResult = '0; StoreData = '0;
        MemRead = 1'b0; MemWrite = 1'b0; MemSize = 2'b00; MemSign = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; Wready = 1'b0;
        step(); step();

        chk("rst_mval",  {31'b0, Mvalid},  32'd0);
        chk("rst_req",   {31'b0, mem_req}, 32'd0);
        chk("rst_we",    {31'b0, mem_we},  32'd0);
        chk("rst_merr",  {31'b0, Merr},    32'd0);
        chk("rst_res",   MemResult, 32'd0);
        chk("rst_alu",   ALUOut, 32'd0);
        chk("rst_addr",  mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_mask",  {28'b0, mem_wmask}, 32'd0);
        chk("rst_mrdy",  {31'b0, Mready}, 32'd1);
        rstn = 1'b1;
        step();

        // Non-memory pass-through, back-to-back handoff.
        run_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 0, 1'b0, 0, 0);
        // lb / lbu at the top lane.
        run_op(1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h5555_AAAA, 32'h80FF_FFFF, 1, 1'b0, 1, 0);
        run_op(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h5555_AAAA, 32'h80FF_FFFF, 0, 1'b0, 0, 0);
        // sh to the upper half with a 3-cycle grant stall.
        run_op(1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 3, 1'b0, 0, 1);
        // Misaligned lw.
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0, 32'hFFFF_FFFF, 0, 1'b0, 0, 0);
        // Grant and response together, writeback stalled 4 cycles.
        run_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 32'hDEAD_BEEF, 0, 1'b1, 0, 4);
        // Read+write together is a load; size 11 behaves as word.
        run_op(1'b1, 1'b1, 2'b11, 1'b1, 32'h0000_5008, 32'h1111_2222, 32'h8765_4321, 1, 1'b0, 2, 0);
        // lh signed from the upper half.
        run_op(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_6002, 32'h0, 32'h9ABC_1234, 0, 1'b0, 0, 0);

        // Reset while waiting for the response; late rvalid must be ignored.
        Evalid = 1'b1; ALUResult = 32'h0000_7004; MemRead = 1'b1; MemWrite = 1'b0;
        MemSize = 2'b10; MemSign = 1'b0;
        step();
        Evalid = 1'b0; mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("rw_in_wait", {31'b0, mem_req}, 32'd0);
        rstn = 1'b0;
        step();
        chk("rw_mval",  {31'b0, Mvalid}, 32'd0);
        chk("rw_res",   MemResult, 32'd0);
        chk("rw_alu",   ALUOut, 32'd0);
        chk("rw_addr",  mem_addr, 32'd0);
        chk("rw_mrdy",  {31'b0, Mready}, 32'd1);
        rstn = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 1'b0;
        chk("rw_late_mval", {31'b0, Mvalid}, 32'd0);
        chk("rw_late_mrdy", {31'b0, Mready}, 32'd1);
        step();
        chk("rw_late_mval2", {31'b0, Mvalid}, 32'd0);

        // Randomized operations.
        for (int n = 0; n < 80; n++) begin
            sz = 2'($urandom);
            case ($urandom_range(0, 3))
                0:       begin rd = 1'b0; wr = 1'b0; end
                1:       begin rd = 1'b1; wr = 1'b0; end
                2:       begin rd = 1'b0; wr = 1'b1; end
                default: begin rd = 1'b1; wr = 1'b1; end
            endcase
            a = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'b00)
                a = a & ((sz == 2'b01) ? 32'hFFFF_FFFE : 32'hFFFF_FFFC);
            run_op(rd, wr, sz, 1'($urandom), a, $urandom, $urandom,
                   $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
